pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised next-generation program counter for the RV32I fetch stage.
- Generalises the PC+4/branch register with configurable width, reset and trap vectors, and three redirect modes: PC-relative branch/JAL, absolute JALR, and trap.
- Adds stall, a fetch valid/ready handshake to instruction memory, target alignment checking, and a boot/run/halt state machine.
- Sits between the execute-stage branch resolution and the instruction memory.

Parameters:
- XLEN, 32, width of the PC and of all address arithmetic.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; truncated to XLEN.
- TRAP_VECTOR, 32'h0000_0100, target for trap redirects; truncated to XLEN.
- INC, 4, sequential increment in bytes; legal values are 2 or 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold the PC; from the hazard unit.
- redirect_valid  in  1  redirect request this cycle.
- redirect_mode  in  2  00 relative, 01 absolute (JALR), 10 trap, 11 reserved.
- redirect_base  in  XLEN  PC of the branching instruction (mode 00) or rs1 value (mode 01).
- redirect_offset  in  XLEN  sign-extended immediate.
- fetch_ready  in  1  instruction memory accepts the current address.
- fetch_valid  out  1  pc is a valid fetch address.
- pc  out  XLEN  current fetch address.
- pc_plus_inc  out  XLEN  pc + INC; used as the link value.
- misaligned  out  1  last requested target was misaligned; sticky while in HALT.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (async): state = BOOT, pc = RESET_VECTOR, misaligned = 0, halted = 0, fetch_valid = 0.
- pc_plus_inc is combinational from pc and always equals (pc + INC) mod 2^XLEN.
- Target computation, all modulo 2^XLEN with carry-out discarded:
  - mode 00: base + offset.
  - mode 01: (base + offset) with bit 0 cleared.
  - mode 10: TRAP_VECTOR.
  - mode 11: treated as no redirect; no state change.
- Alignment check on modes 00 and 01 only:
  - INC = 4: target[1:0] must be 0.
  - INC = 2: target[0] must be 0.
- FSM states:
  - BOOT: fetch_valid = 0. Next edge goes to RUN and pc is unchanged, unless a trap redirect is present, in which case pc = TRAP_VECTOR and state = RUN.
  - RUN: fetch_valid = 1.
  - HALT: fetch_valid = 0, halted = 1, misaligned = 1, pc frozen at its pre-redirect value.
- Priority in RUN, evaluated per rising edge:
  - 1. Trap redirect: pc = TRAP_VECTOR, misaligned = 0. Ignores stall and fetch_ready.
  - 2. Mode 00/01 redirect, aligned: pc = target. Ignores stall and fetch_ready; the in-flight fetch is abandoned and flushing is the pipeline's responsibility.
  - 3. Mode 00/01 redirect, misaligned: pc unchanged, state = HALT, misaligned = 1.
  - 4. stall = 1: pc held.
  - 5. fetch_ready = 1: pc = pc + INC.
  - 6. Otherwise: pc held. fetch_valid stays high and pc stays stable until accepted.
- HALT exits only via a trap redirect (-> RUN, pc = TRAP_VECTOR, misaligned = 0) or via reset. Other redirects, stall and fetch_ready are ignored in HALT.
- Wrap-around: pc = 2^XLEN - INC with fetch accepted -> pc = 0; no flag raised.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.
- Latency: a redirect presented in cycle N appears on pc after the edge ending cycle N (one cycle).
- Redirect inputs are sampled only while redirect_valid = 1.

Test Plan:
- Reset release, RESET_VECTOR = 0, fetch_ready = 1: fetch_valid 0 for one cycle, then pc = 0, 4, 8, 12 on successive edges; pc_plus_inc = pc + 4 throughout.
- Handshake: fetch_ready low for 3 cycles at pc = 0x10 -> pc holds 0x10 with fetch_valid = 1; ready high -> pc = 0x14. stall = 1 with ready = 1 -> pc held.
- Relative redirect, base = 0x40, offset = 0xFFFF_FFF0, during stall -> pc = 0x30 next cycle. JALR, base = 0x101, offset = 0x4 -> pc = 0x104.
- Misaligned JALR, base = 0x100, offset = 0x2 -> pc stays at prior value, halted = 1, misaligned = 1, fetch_valid = 0. Then a mode-00 redirect -> ignored. Then a trap -> pc = 0x100, halted = 0, misaligned = 0.
- Wrap: pc at 0xFFFF_FFFC with fetch accepted -> pc = 0x0. Trap and mode-00 redirect on the same edge is not possible (single mode field); instead, trap in BOOT -> pc = 0x100 and state = RUN.
- Async reset asserted mid-cycle in RUN at pc = 0x88 -> pc = 0 without waiting for a clock edge. Repeat with XLEN = 16, INC = 2: sequence 0, 2, 4, and target 0x0003 halts.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: RV32I fetch-stage program counter with redirect, stall, fetch handshake and boot/run/halt FSM
//   clk, rst          clock; asynchronous active-high reset
//   stall             hold the pc (hazard unit)
//   redirect_valid    redirect request this cycle
//   redirect_mode     00 relative, 01 absolute (JALR), 10 trap, 11 reserved (no effect)
//   redirect_base     branch pc (mode 00) or rs1 (mode 01)
//   redirect_offset   sign-extended immediate
//   fetch_ready       instruction memory accepts pc
//   fetch_valid       pc is a valid fetch address
//   pc, pc_plus_inc   current fetch address and its link value pc + INC
//   misaligned        last requested target was misaligned (held while halted)
//   halted            FSM is in HALT
module pc_unit #(
   parameter int unsigned XLEN = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
   parameter int unsigned INC = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [1:0]      redirect_mode,
   input  logic [XLEN-1:0] redirect_base,
   input  logic [XLEN-1:0] redirect_offset,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_inc,
   output logic            misaligned,
   output logic            halted
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   localparam logic [XLEN-1:0] RV = RESET_VECTOR[XLEN-1:0];
   localparam logic [XLEN-1:0] TV = TRAP_VECTOR[XLEN-1:0];
   localparam logic [XLEN-1:0] INC_W = INC[XLEN-1:0];
   state_t state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, sum, target;
   logic mis_q, mis_d, trap, jump, bad;
   assign sum = redirect_base + redirect_offset;
   // JALR clears bit 0 of the computed target
   assign target = redirect_mode[0] ? {sum[XLEN-1:1], 1'b0} : sum;
   assign bad = (INC == 2) ? target[0] : |target[1:0];
   assign trap = redirect_valid && redirect_mode == 2'b10;
   assign jump = redirect_valid && !redirect_mode[1];
   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      mis_d = mis_q;
      case (state_q)
         BOOT: begin
            state_d = RUN;
            pc_d = trap ? TV : pc_q;
         end
         RUN: begin
            if (trap) begin
               pc_d = TV;
               mis_d = 1'b0;
            end else if (jump) begin
               // a misaligned target freezes pc at its pre-redirect value
               state_d = bad ? HALT : RUN;
               mis_d = bad;
               pc_d = bad ? pc_q : target;
            end else if (!stall && fetch_ready) begin
               pc_d = pc_q + INC_W;
            end
         end
         HALT: begin
            if (trap) begin
               state_d = RUN;
               pc_d = TV;
               mis_d = 1'b0;
            end
         end
         default: state_d = BOOT;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q <= RV;
         mis_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         mis_q <= mis_d;
      end
   end
   assign pc = pc_q;
   assign pc_plus_inc = pc_q + INC_W;
   assign misaligned = mis_q;
   assign fetch_valid = state_q == RUN;
   assign halted = state_q == HALT;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (32-bit/INC 4 and 16-bit/INC 2 instances)
module tb_pc_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   logic rst, stall, rv, fr, fv, mis, hlt;
   logic [1:0] rm;
   logic [31:0] rb, ro, pc, ppi;
   pc_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_mode(rm),
      .redirect_base(rb), .redirect_offset(ro), .fetch_ready(fr), .fetch_valid(fv),
      .pc(pc), .pc_plus_inc(ppi), .misaligned(mis), .halted(hlt)
   );
   logic b_rst, b_stall, b_rv, b_fr, b_fv, b_mis, b_hlt;
   logic [1:0] b_rm;
   logic [15:0] b_rb, b_ro, b_pc, b_ppi;
   pc_unit #(.XLEN(16), .INC(2)) dut_b (
      .clk(clk), .rst(b_rst), .stall(b_stall), .redirect_valid(b_rv), .redirect_mode(b_rm),
      .redirect_base(b_rb), .redirect_offset(b_ro), .fetch_ready(b_fr), .fetch_valid(b_fv),
      .pc(b_pc), .pc_plus_inc(b_ppi), .misaligned(b_mis), .halted(b_hlt)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic redir(input logic [1:0] m, input logic [31:0] b, input logic [31:0] o);
      rv = 1'b1;
      rm = m;
      rb = b;
      ro = o;
      step();
      rv = 1'b0;
   endtask
   task automatic st(input string tag, input logic [31:0] p, input logic v, input logic h, input logic m);
      check({tag, "_pc"}, pc, p);
      check({tag, "_fv"}, {31'd0, fv}, {31'd0, v});
      check({tag, "_halt"}, {31'd0, hlt}, {31'd0, h});
      check({tag, "_mis"}, {31'd0, mis}, {31'd0, m});
   endtask
   initial begin
      rst = 1'b1; stall = 1'b0; rv = 1'b0; rm = 2'b00; rb = '0; ro = '0; fr = 1'b1;
      b_rst = 1'b1; b_stall = 1'b0; b_rv = 1'b0; b_rm = 2'b00; b_rb = '0; b_ro = '0; b_fr = 1'b1;
      step();
      step();
      st("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      check("reset_ppi", ppi, 32'h4);
      @(negedge clk);
      rst = 1'b0;
      step();
      st("boot_exit", 32'h0, 1'b1, 1'b0, 1'b0);
      step();
      check("seq4", pc, 32'h4);
      check("seq4_ppi", ppi, 32'h8);
      step();
      check("seq8", pc, 32'h8);
      step();
      check("seq12", pc, 32'hC);
      check("seq12_ppi", ppi, 32'h10);
      step();
      check("seq16", pc, 32'h10);
      fr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("notready_pc", pc, 32'h10);
         check("notready_fv", {31'd0, fv}, 32'd1);
      end
      fr = 1'b1;
      step();
      check("accept", pc, 32'h14);
      stall = 1'b1;
      step();
      check("stall", pc, 32'h14);
      redir(2'b00, 32'h40, 32'hFFFF_FFF0);
      stall = 1'b0;
      check("rel_during_stall", pc, 32'h30);
      redir(2'b01, 32'h101, 32'h4);
      check("jalr", pc, 32'h104);
      redir(2'b01, 32'h100, 32'h2);
      st("mis_jalr", 32'h104, 1'b0, 1'b1, 1'b1);
      redir(2'b00, 32'h0, 32'h0);
      st("halt_ignore", 32'h104, 1'b0, 1'b1, 1'b1);
      redir(2'b10, 32'h0, 32'h0);
      st("halt_trap", 32'h100, 1'b1, 1'b0, 1'b0);
      fr = 1'b0;
      redir(2'b11, 32'h40, 32'h0);
      check("mode11", pc, 32'h100);
      fr = 1'b1;
      redir(2'b00, 32'hFFFF_FFF8, 32'h0);
      check("pre_wrap", pc, 32'hFFFF_FFF8);
      step();
      check("wrap_fffc", pc, 32'hFFFF_FFFC);
      check("wrap_ppi", ppi, 32'h0);
      step();
      st("wrap_0", 32'h0, 1'b1, 1'b0, 1'b0);
      fr = 1'b0;
      redir(2'b00, 32'h88, 32'h0);
      check("pre_async", pc, 32'h88);
      #2;
      rst = 1'b1;
      #1;
      st("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      redir(2'b10, 32'h0, 32'h0);
      st("boot_trap", 32'h100, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      b_rst = 1'b0;
      step();
      check("b_boot", {16'd0, b_pc}, 32'h0);
      check("b_fv", {31'd0, b_fv}, 32'd1);
      step();
      check("b_seq2", {16'd0, b_pc}, 32'h2);
      step();
      check("b_seq4", {16'd0, b_pc}, 32'h4);
      check("b_ppi", {16'd0, b_ppi}, 32'h6);
      b_rv = 1'b1; b_rm = 2'b00; b_rb = 16'h0003; b_ro = 16'h0;
      step();
      b_rv = 1'b0;
      check("b_mis_pc", {16'd0, b_pc}, 32'h4);
      check("b_mis_halt", {31'd0, b_hlt}, 32'd1);
      check("b_mis_flag", {31'd0, b_mis}, 32'd1);
      check("b_mis_fv", {31'd0, b_fv}, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
